// File: rtl/pbdebounce_multi_if.sv
//------------------------------------------------------------------------------
// pbdebounce_multi_if
//
// Bundle of the push-button conditioner's control and status signals.
//
// Signals:
//   en           sampling enable (low freezes prescaler and channel state)
//   btn_in       raw asynchronous button inputs, one bit per channel
//   level        debounced level per channel
//   rise_pulse   one-clk pulse on accepted 0->1
//   fall_pulse   one-clk pulse on accepted 1->0
//   repeat_pulse one-clk auto-repeat pulse
//
// Modports:
//   master : drives en/btn_in, observes the conditioned outputs
//   slave  : the conditioner itself
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pbdebounce_multi_if #(
   parameter int CHANNELS = 4
);
   logic                en;
   logic [CHANNELS-1:0] btn_in;
   logic [CHANNELS-1:0] level;
   logic [CHANNELS-1:0] rise_pulse;
   logic [CHANNELS-1:0] fall_pulse;
   logic [CHANNELS-1:0] repeat_pulse;

   modport master (
      output en, btn_in,
      input  level, rise_pulse, fall_pulse, repeat_pulse
   );

   modport slave (
      input  en, btn_in,
      output level, rise_pulse, fall_pulse, repeat_pulse
   );
endinterface

`default_nettype wire

// File: rtl/pbdebounce_multi.sv
//------------------------------------------------------------------------------
// pbdebounce_multi
//
// Multi-channel push-button conditioner. Each channel has a 2-flop
// synchroniser, a debouncer that accepts a new level after SAMPLES
// consecutive differing samples taken on a shared prescaler tick, one-clk
// rise/fall pulses and an optional auto-repeat generator.
//
// Optional feature macro: DEBOUNCE_AUTOREPEAT_EN
//   defined   : per-channel auto-repeat FSM drives repeat_pulse
//   undefined : no repeat logic, repeat_pulse tied to 0
//
// Ports:
//   clk   system clock, rising edge
//   rst_n asynchronous active-low reset
//   bus   pbdebounce_multi_if.slave (en, btn_in in; level, rise_pulse,
//         fall_pulse, repeat_pulse out)
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pbdebounce_multi #(
   parameter int CHANNELS     = 4,
   parameter int TICK_DIV     = 100000,
   parameter int SAMPLES      = 8,
   parameter int RESET_LEVEL  = 0,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   pbdebounce_multi_if.slave   bus
);

   localparam int              c_PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int              c_CW         = $clog2(SAMPLES + 1);
   localparam logic [c_PW-1:0] c_PRE_LAST   = c_PW'(TICK_DIV - 1);
   localparam logic [c_CW-1:0] c_CNT_LAST   = c_CW'(SAMPLES - 1);
   localparam logic            c_RST_LEVEL  = (RESET_LEVEL != 0);

   if ((CHANNELS < 1) || (CHANNELS > 32) || (TICK_DIV < 1) ||
       (SAMPLES < 2) || (SAMPLES > 255) ||
       (RESET_LEVEL < 0) || (RESET_LEVEL > 1) ||
       (REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_bad_param
      $error("pbdebounce_multi: parameter out of range");
   end

`ifdef DEBOUNCE_AUTOREPEAT_EN
   localparam int              c_RMAX       = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int              c_RW         = $clog2(c_RMAX + 1);
   localparam logic [c_RW-1:0] c_RDLY_LAST  = c_RW'(REPEAT_DELAY - 1);
   localparam logic [c_RW-1:0] c_RRATE_LAST = c_RW'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DELAY  = 2'd1,
      S_REPEAT = 2'd2
   } rep_state_t;
`endif

   // Shared sample-tick prescaler; a TICK_DIV of 1 keeps r_pre at 0 so the
   // tick simply follows en.
   logic [c_PW-1:0]     r_pre;
   logic                w_tick;
   logic [CHANNELS-1:0] w_level;
   logic [CHANNELS-1:0] w_rise;
   logic [CHANNELS-1:0] w_fall;
   logic [CHANNELS-1:0] w_rep;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
      end else if (bus.en) begin
         r_pre <= (r_pre == c_PRE_LAST) ? '0 : r_pre + 1'b1;
      end
   end

   assign w_tick = bus.en && (r_pre == c_PRE_LAST);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic            r_s1;
      logic            r_s2;
      logic            r_level;
      logic            r_rise;
      logic            r_fall;
      logic [c_CW-1:0] r_cnt;
      logic            w_accept;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_s1 <= c_RST_LEVEL;
            r_s2 <= c_RST_LEVEL;
         end else begin
            r_s1 <= bus.btn_in[g];
            r_s2 <= r_s1;
         end
      end

      // The SAMPLES-th consecutive differing sample is the accepting one.
      assign w_accept = w_tick && (r_s2 != r_level) && (r_cnt == c_CNT_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_level <= c_RST_LEVEL;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
         end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_tick) begin
               if (r_s2 == r_level) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_CNT_LAST) begin
                  r_level <= r_s2;
                  r_cnt   <= '0;
                  r_rise  <= r_s2;
                  r_fall  <= ~r_s2;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end
      end

      assign w_level[g] = r_level;
      assign w_rise[g]  = r_rise;
      assign w_fall[g]  = r_fall;

`ifdef DEBOUNCE_AUTOREPEAT_EN
      rep_state_t      r_state;
      rep_state_t      w_state_nx;
      logic [c_RW-1:0] r_rcnt;
      logic [c_RW-1:0] w_rcnt_nx;
      logic            r_rep;
      logic            w_rep_nx;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state <= S_IDLE;
            r_rcnt  <= '0;
            r_rep   <= 1'b0;
         end else begin
            r_state <= w_state_nx;
            r_rcnt  <= w_rcnt_nx;
            r_rep   <= w_rep_nx;
         end
      end

      // The accepting tick only arms DELAY; counting starts on the next tick,
      // so a rise pulse and a repeat pulse can never share a cycle.
      always_comb begin
         w_state_nx = r_state;
         w_rcnt_nx  = r_rcnt;
         w_rep_nx   = 1'b0;
         if (w_accept && !r_s2) begin
            w_state_nx = S_IDLE;
            w_rcnt_nx  = '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept && r_s2) begin
                     w_state_nx = S_DELAY;
                     w_rcnt_nx  = '0;
                  end
               end
               S_DELAY: begin
                  if (w_tick) begin
                     if (r_rcnt == c_RDLY_LAST) begin
                        w_rep_nx   = 1'b1;
                        w_rcnt_nx  = '0;
                        w_state_nx = S_REPEAT;
                     end else begin
                        w_rcnt_nx = r_rcnt + 1'b1;
                     end
                  end
               end
               S_REPEAT: begin
                  if (w_tick) begin
                     if (r_rcnt == c_RRATE_LAST) begin
                        w_rep_nx  = 1'b1;
                        w_rcnt_nx = '0;
                     end else begin
                        w_rcnt_nx = r_rcnt + 1'b1;
                     end
                  end
               end
               default: begin
                  w_state_nx = S_IDLE;
                  w_rcnt_nx  = '0;
               end
            endcase
         end
      end

      assign w_rep[g] = r_rep;
`else
      assign w_rep[g] = 1'b0;
`endif
   end

   assign bus.level        = w_level;
   assign bus.rise_pulse   = w_rise;
   assign bus.fall_pulse   = w_fall;
   assign bus.repeat_pulse = w_rep;

endmodule

`default_nettype wire

// File: tb/tb_pbdebounce_multi.sv
//------------------------------------------------------------------------------
// tb_pbdebounce_multi
//
// Self-checking bench for pbdebounce_multi with CHANNELS=4, TICK_DIV=4,
// SAMPLES=4, REPEAT_DELAY=6, REPEAT_RATE=3, RESET_LEVEL=0.
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pbdebounce_multi;

   localparam int CH = 4;

   logic clk;
   logic rst_n;

   pbdebounce_multi_if #(.CHANNELS(CH)) bus ();

   pbdebounce_multi #(
      .CHANNELS     (CH),
      .TICK_DIV     (4),
      .SAMPLES      (4),
      .RESET_LEVEL  (0),
      .REPEAT_DELAY (6),
      .REPEAT_RATE  (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] btn;
      logic       en;
      int         cycles;
      logic [3:0] exp_level;
      int         exp_rise;
      int         exp_fall;
   } vec_t;

   vec_t tbl [10];

   int errors    = 0;
   int checks    = 0;
   int rise_acc  = 0;
   int fall_acc  = 0;
   int rep_acc   = 0;
   int rep_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if ((act < lo) || (act > hi)) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // One clock: sample #1 after the rising edge, accumulate pulse bits.
   task automatic step();
      @(posedge clk);
      #1;
      rise_acc  += $countones(bus.rise_pulse);
      fall_acc  += $countones(bus.fall_pulse);
      rep_acc   += $countones(bus.repeat_pulse);
      rep_total += $countones(bus.repeat_pulse);
   endtask

   task automatic clear_acc();
      rise_acc = 0;
      fall_acc = 0;
      rep_acc  = 0;
   endtask

   function automatic logic sig_bit(input int which, input int idx);
      case (which)
         0:       return bus.level[idx];
         1:       return bus.rise_pulse[idx];
         2:       return bus.fall_pulse[idx];
         default: return bus.repeat_pulse[idx];
      endcase
   endfunction

   // Steps until the selected bit equals val; n = clocks taken (41 on timeout).
   task automatic wait_bit(input int which, input int idx, input logic val, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while ((sig_bit(which, idx) !== val) && (n <= 40));
   endtask

   int   n;
   int   changes;

   initial begin
      tbl[0] = '{4'b0000, 1'b1, 24, 4'b0000, 0, 0};
      tbl[1] = '{4'b0001, 1'b1, 24, 4'b0001, 1, 0};
      tbl[2] = '{4'b0011, 1'b1, 24, 4'b0011, 1, 0};
      tbl[3] = '{4'b0001, 1'b1,  8, 4'b0011, 0, 0};  // short glitch on ch1
      tbl[4] = '{4'b0011, 1'b1, 24, 4'b0011, 0, 0};
      tbl[5] = '{4'b1100, 1'b1, 24, 4'b1100, 2, 2};
      tbl[6] = '{4'b0000, 1'b0, 30, 4'b1100, 0, 0};  // frozen
      tbl[7] = '{4'b0000, 1'b1, 24, 4'b0000, 0, 2};
      tbl[8] = '{4'b1111, 1'b1,  4, 4'b0000, 0, 0};  // glitch on all
      tbl[9] = '{4'b0000, 1'b1, 24, 4'b0000, 0, 0};

      rst_n      = 1'b0;
      bus.en     = 1'b0;
      bus.btn_in = 4'b0000;
      repeat (3) step();
      check("reset_level", {28'd0, bus.level}, 32'h0);
      check("reset_rise", {28'd0, bus.rise_pulse}, 32'h0);
      check("reset_fall", {28'd0, bus.fall_pulse}, 32'h0);
      check("reset_repeat", {28'd0, bus.repeat_pulse}, 32'h0);
      rst_n = 1'b1;
      step();

      // Table-driven vectors
      for (int i = 0; i < 10; i++) begin
         bus.btn_in = tbl[i].btn;
         bus.en     = tbl[i].en;
         clear_acc();
         repeat (tbl[i].cycles) step();
         check($sformatf("vec%0d_level", i), {28'd0, bus.level}, {28'd0, tbl[i].exp_level});
         check($sformatf("vec%0d_rise", i), rise_acc, tbl[i].exp_rise);
         check($sformatf("vec%0d_fall", i), fall_acc, tbl[i].exp_fall);
      end

      // Clean press on ch0
      bus.btn_in = 4'b0001;
      clear_acc();
      wait_bit(0, 0, 1'b1, n);
      check_range("press_latency", n, 15, 18);
      check("press_rise", {28'd0, bus.rise_pulse}, 32'h1);
      check("press_fall", {28'd0, bus.fall_pulse}, 32'h0);
      check("press_level", {28'd0, bus.level}, 32'h1);
      step();
      check("press_rise_1clk", {28'd0, bus.rise_pulse}, 32'h0);

      // Bounce on ch1: toggles every 5 clk for 60 clk, ending low
      clear_acc();
      for (int i = 0; i < 12; i++) begin
         bus.btn_in[1] = ~bus.btn_in[1];
         repeat (5) step();
      end
      check("bounce_no_pulses", rise_acc + fall_acc, 0);
      bus.btn_in[1] = 1'b1;
      clear_acc();
      wait_bit(0, 1, 1'b1, n);
      check_range("bounce_latency", n, 15, 18);
      repeat (25) step();
      check("bounce_one_rise", rise_acc, 1);

      // Simultaneous rise on ch0 and fall on ch2
      bus.btn_in = 4'b0100;
      repeat (30) step();
      check("simul_pre_level", {28'd0, bus.level}, 32'h4);
      bus.btn_in = 4'b0001;
      n = 0;
      do begin
         step();
         n++;
      end while ((bus.level === 4'b0100) && (n <= 40));
      check("simul_rise", {28'd0, bus.rise_pulse}, 32'h1);
      check("simul_fall", {28'd0, bus.fall_pulse}, 32'h4);
      check("simul_level", {28'd0, bus.level}, 32'h1);

      // Enable freeze on ch3 after exactly two counted ticks
      repeat (20) step();
      bus.btn_in = 4'b1001;
      repeat (10) step();
      bus.en  = 1'b0;
      changes = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus.level[3] !== 1'b0) changes++;
      end
      check("freeze_held", changes, 0);
      bus.en = 1'b1;
      wait_bit(0, 3, 1'b1, n);
      check_range("freeze_resume", n, 1, 8);
      check("freeze_level", {28'd0, bus.level}, 32'h9);

      // Reset mid-count with all levels high
      bus.btn_in = 4'b1111;
      repeat (30) step();
      check("rst_pre_level", {28'd0, bus.level}, 32'hF);
      bus.btn_in = 4'b0000;
      repeat (6) step();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_level", {28'd0, bus.level}, 32'h0);
      check("rst_async_pulses", {28'd0, bus.rise_pulse | bus.fall_pulse | bus.repeat_pulse}, 32'h0);
      step();
      step();
      rst_n = 1'b1;
      clear_acc();
      repeat (40) step();
      check("rst_release_pulses", rise_acc + fall_acc + rep_acc, 0);
      check("rst_release_level", {28'd0, bus.level}, 32'h0);

`ifdef DEBOUNCE_AUTOREPEAT_EN
      // Auto-repeat on ch2
      bus.btn_in = 4'b0100;
      wait_bit(1, 2, 1'b1, n);
      check_range("rep_rise_seen", n, 15, 18);
      check("rep_no_coincide", {31'd0, bus.repeat_pulse[2]}, 32'h0);
      wait_bit(3, 2, 1'b1, n);
      check("rep_first_delay", n, 24);
      wait_bit(3, 2, 1'b1, n);
      check("rep_period_1", n, 12);
      wait_bit(3, 2, 1'b1, n);
      check("rep_period_2", n, 12);
      bus.btn_in = 4'b0000;
      wait_bit(2, 2, 1'b1, n);
      check_range("rep_fall_seen", n, 1, 30);
      clear_acc();
      repeat (40) step();
      check("rep_stopped", rep_acc, 0);
`else
      bus.btn_in = 4'b0100;
      repeat (80) step();
      check("rep_hold_level", {28'd0, bus.level}, 32'h4);
      check("rep_disabled_zero", rep_total, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pbdebounce_multi.md
# pbdebounce_multi

Parametrised multi-channel push-button conditioner for board inputs such as keys and switches. Per channel it provides a 2-flop synchroniser, an internal sample-tick prescaler, debouncing by N consecutive identical samples, one-cycle rise/fall pulses and, optionally, key auto-repeat. It sits between raw pad inputs and control logic (ALU operand entry, counters, FSM stepping), all in the system clock domain.

## Interface
- CHANNELS, 4, number of independent button channels (1..32)
- TICK_DIV, 100000, clk cycles per sample tick (1 = sample every cycle)
- SAMPLES, 8, consecutive differing samples required to accept a new level (2..255)
- RESET_LEVEL, 0, debounced level and synchroniser value during and after reset (0 or 1)
- REPEAT_DELAY, 500, ticks of held-high level before the first repeat pulse (≥1)
- REPEAT_RATE, 100, ticks between subsequent repeat pulses (≥1)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  sampling enable; low freezes the prescaler and all channel state
- btn_in  input  CHANNELS  raw asynchronous button inputs
- level  output  CHANNELS  debounced level, registered
- rise_pulse  output  CHANNELS  one-clk pulse on accepted 0→1
- fall_pulse  output  CHANNELS  one-clk pulse on accepted 1→0
- repeat_pulse  output  CHANNELS  one-clk auto-repeat pulse (constant 0 when feature compiled out)

## Operation
- Sync: two flops per channel; both reset to RESET_LEVEL. The debouncer sees only the second flop (sync).
- Prescaler: counter 0..TICK_DIV-1, increments when en=1. tick=1 for one cycle when count==TICK_DIV-1 and en=1, then wraps to 0. TICK_DIV=1 gives tick=en. en=0 holds the count and tick=0.
- Per-channel counter cnt (width $clog2(SAMPLES+1)), evaluated only on tick:
  - sync==level: cnt←0.
  - sync!=level and cnt+1<SAMPLES: cnt←cnt+1.
  - sync!=level and cnt+1==SAMPLES: level←sync, cnt←0, and rise_pulse or fall_pulse asserted on the same edge.
- Any sample that matches the current level restarts the count. Bounces shorter than SAMPLES ticks produce no output activity.
- Channels are fully independent. Simultaneous events on several channels assert their pulse bits in the same cycle.
- Auto-repeat FSM per channel (macro enabled):
  - States: IDLE, DELAY, REPEAT. Counter rcnt, width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
  - IDLE→DELAY on accepted rise; rcnt←0.
  - DELAY: on each tick rcnt++. When rcnt reaches REPEAT_DELAY: repeat_pulse, rcnt←0, go to REPEAT.
  - REPEAT: on each tick rcnt++. When rcnt reaches REPEAT_RATE: repeat_pulse, rcnt←0.
  - Accepted fall in any state → IDLE, rcnt←0, no repeat pulse in that cycle.
  - The tick that accepts the rise does not count toward REPEAT_DELAY.

## Timing
- Reset (async assert, release sampled on clk): level=RESET_LEVEL on all bits; rise_pulse, fall_pulse and repeat_pulse =0; prescaler=0; cnt=0; FSM=IDLE.
- Reset asserted mid-count clears everything immediately. No pulse is emitted on release, because sync and level both equal RESET_LEVEL.
- Press latency, from input edge to level change: 2 + k + (SAMPLES-1)·TICK_DIV cycles, where k∈[1,TICK_DIV] is the phase to the first tick.
- Pulses last exactly one clk and are high on the cycle level changes. A rise pulse and a repeat pulse never coincide on one channel.
- en deasserted mid-count: cnt, rcnt and FSM are held. Counting resumes at the next tick after en=1.

## Configuration
- DEBOUNCE_AUTOREPEAT_EN defined: the auto-repeat FSM and rcnt are instantiated per channel, and repeat_pulse behaves as specified above.
- DEBOUNCE_AUTOREPEAT_EN undefined: no repeat logic is built, and repeat_pulse is tied to 0. REPEAT_DELAY and REPEAT_RATE are ignored.

## Test plan
Bench parameters: CHANNELS=4, TICK_DIV=4, SAMPLES=4, REPEAT_DELAY=6, REPEAT_RATE=3.
- Clean press: btn_in[0] 0→1 and held → level[0]=1 between 15 and 18 clk after the edge; rise_pulse=4'b0001 for exactly 1 clk; no other bits toggle.
- Bounce: btn_in[1] toggles every 5 clk for 60 clk, then held 1 → zero pulses during the bounce; exactly one rise_pulse[1] 15..18 clk after the final edge.
- Simultaneous events: with level=4'b0100, btn_in[0] rises and btn_in[2] falls on the same cycle → one cycle with rise_pulse=4'b0001 and fall_pulse=4'b0100; level=4'b0001 afterwards.
- Enable freeze: change btn_in[3], drop en for 40 clk after 2 ticks → level[3] unchanged while en=0; accepted 2 ticks (≤8 clk) after en=1.
- Reset mid-operation: assert rst_n=0 with cnt partially counted and level=4'b1111 → level=0 and all pulses 0 immediately; with btn_in=0, no pulses after release.
- Auto-repeat (macro enabled): hold btn_in[2]=1 → repeat_pulse[2] 24 clk after rise_pulse[2], then every 12 clk; release → pulses stop. Macro disabled → repeat_pulse stays 0.
